// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix multiply sequencer.
//   state_t  : sequencer states (IDLE=0, MAC=1, WRITE=2, DONE=3)
//   ADDR_W   : memory address width (6 bits, 64 elements)
//   rm_addr  : row-major element address, row*n+col
package matmul_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MAC   = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int ADDR_W = 6;

   function automatic logic [ADDR_W-1:0] rm_addr(input int row, input int col, input int n);
      return ADDR_W'(row * n + col);
   endfunction

endpackage

// File: rtl/matmul_controller_mac_unit.sv
// Multiply-accumulate unit for the matrix multiply sequencer.
// Ports:
//   clk, rst   : clock, synchronous active-low reset
//   clr        : clear acc on the next edge (wins over en)
//   en         : add a*b into acc on the next edge
//   a, b       : unsigned operands (SIZE bits)
//   acc        : accumulator (ACC_W bits, sized so it cannot overflow)
//   result     : acc reduced to SIZE bits; saturates to all-ones when
//                MATMUL_SATURATE_EN is defined, otherwise truncates.
module mac_unit #(
   parameter int SIZE  = 8,
   parameter int ACC_W = 18
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [SIZE-1:0]  a,
   input  logic [SIZE-1:0]  b,
   output logic [ACC_W-1:0] acc,
   output logic [SIZE-1:0]  result
);

   logic [2*SIZE-1:0] prod;

   assign prod = {{SIZE{1'b0}}, a} * {{SIZE{1'b0}}, b};

   always_ff @(posedge clk) begin
      if (!rst)
         acc <= '0;
      else if (clr)
         acc <= '0;
      else if (en)
         acc <= acc + {{(ACC_W-2*SIZE){1'b0}}, prod};
   end

`ifdef MATMUL_SATURATE_EN
   // Any bit above the element width means the value does not fit.
   assign result = (|acc[ACC_W-1:SIZE]) ? {SIZE{1'b1}} : acc[SIZE-1:0];
`else
   assign result = acc[SIZE-1:0];
`endif

endmodule

// File: rtl/matmul_controller.sv
// Matrix multiply sequencer: C = A x B for square N x N unsigned matrices,
// one multiply-accumulate per cycle, then one write per C element.
// Optional saturation of results is compiled in with MATMUL_SATURATE_EN.
// Ports:
//   clk, rst          : clock, synchronous active-low reset
//   start             : begin a multiply (accepted only in IDLE)
//   busy, done        : busy in MAC/WRITE; done pulses one cycle at the end
//   a_read/a_addr     : read port of A (a_data is asynchronous read data)
//   b_read/b_addr     : read port of B (b_data is asynchronous read data)
//   c_write/c_addr/c_data : write port of C
module matmul_controller
   import matmul_pkg::*;
#(
   parameter int N    = 2,
   parameter int SIZE = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              a_read,
   output logic [ADDR_W-1:0] a_addr,
   input  logic [SIZE-1:0]   a_data,
   output logic              b_read,
   output logic [ADDR_W-1:0] b_addr,
   input  logic [SIZE-1:0]   b_data,
   output logic              c_write,
   output logic [ADDR_W-1:0] c_addr,
   output logic [SIZE-1:0]   c_data
);

   localparam int ACC_W = 2*SIZE + $clog2(N) + 1;
   localparam int CW    = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N-1);

   state_t          state, state_nx;
   logic [CW-1:0]   i, j, k;
   logic [ACC_W-1:0] acc;
   logic [SIZE-1:0] result;

   // acc is only live in MAC; clearing it everywhere else gives the
   // zero start on acceptance and the per-element clear after WRITE.
   mac_unit #(.SIZE(SIZE), .ACC_W(ACC_W)) u_mac (
      .clk    (clk),
      .rst    (rst),
      .clr    (state != MAC),
      .en     (state == MAC),
      .a      (a_data),
      .b      (b_data),
      .acc    (acc),
      .result (result)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         i     <= '0;
         j     <= '0;
         k     <= '0;
      end else begin
         state <= state_nx;
         case (state)
            MAC:   k <= (k == LAST) ? '0 : k + CW'(1);
            WRITE: begin
               if (j == LAST) begin
                  j <= '0;
                  i <= i + CW'(1);
               end else begin
                  j <= j + CW'(1);
               end
            end
            default: begin
               i <= '0;
               j <= '0;
               k <= '0;
            end
         endcase
      end
   end

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      a_read   = 1'b0;
      b_read   = 1'b0;
      a_addr   = '0;
      b_addr   = '0;
      c_write  = 1'b0;
      c_addr   = '0;
      c_data   = '0;
      case (state)
         IDLE: if (start) state_nx = MAC;
         MAC: begin
            busy   = 1'b1;
            a_read = 1'b1;
            b_read = 1'b1;
            a_addr = rm_addr(int'(i), int'(k), N);
            b_addr = rm_addr(int'(k), int'(j), N);
            if (k == LAST) state_nx = WRITE;
         end
         WRITE: begin
            busy    = 1'b1;
            c_write = 1'b1;
            c_addr  = rm_addr(int'(i), int'(j), N);
            c_data  = result;
            state_nx = (i == LAST && j == LAST) ? DONE : MAC;
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_matmul_controller.sv
// Directed bench for matmul_controller (N=2, SIZE=8). A cycle-count model
// predicts every output each cycle; per-run logs are checked against
// hand-computed values.
module tb_matmul_controller;

   localparam int N  = 2;
   localparam int DT = N*N*(N+1) + 1;   // model time of the done cycle
`ifdef MATMUL_SATURATE_EN
   localparam int OVF = 255;
`else
   localparam int OVF = 128;
`endif

   logic       clk = 1'b0;
   logic       rst, start;
   logic       busy, done, a_read, b_read, c_write;
   logic [5:0] a_addr, b_addr, c_addr;
   logic [7:0] a_data, b_data, c_data;

   logic [7:0] mem_a [64];
   logic [7:0] mem_b [64];
   logic [7:0] cmem  [64];

   int checks = 0, passed = 0;
   int t = 0;            // model: 0 idle, 1..DT cycles since accepting edge
   bit chk_en = 1'b0;

   int first_wr, done_cyc, done_n, nwr;
   int wr_addr [16];
   int wr_cyc  [16];

   always #5 clk = ~clk;

   assign a_data = mem_a[a_addr];
   assign b_data = mem_b[b_addr];

   matmul_controller #(.N(N), .SIZE(8)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .a_read(a_read), .a_addr(a_addr), .a_data(a_data),
      .b_read(b_read), .b_addr(b_addr), .b_data(b_data),
      .c_write(c_write), .c_addr(c_addr), .c_data(c_data)
   );

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
   endtask

   function automatic int exp_c(input int idx);
      int s = 0;
      for (int kk = 0; kk < N; kk++)
         s += int'(mem_a[(idx/N)*N+kk]) * int'(mem_b[kk*N+idx%N]);
`ifdef MATMUL_SATURATE_EN
      return (s > 255) ? 255 : s;
`else
      return s % 256;
`endif
   endfunction

   // Model: a run is just a count of cycles since the accepting edge.
   always @(posedge clk) begin
      if (!rst)              t <= 0;
      else if (t == 0)       t <= start ? 1 : 0;
      else if (t == DT)      t <= 0;
      else                   t <= t + 1;
      if (c_write) cmem[c_addr] <= c_data;
      chk_en <= 1'b1;
   end

   always @(negedge clk) begin
      int e_busy, e_done, e_rd, e_wr, e_aa, e_ba, e_ca, e_cd, e, kk;
      if (chk_en) begin
         e_busy = 0; e_done = 0; e_rd = 0; e_wr = 0;
         e_aa = 0; e_ba = 0; e_ca = 0; e_cd = 0;
         if (t == DT) e_done = 1;
         else if (t != 0) begin
            e_busy = 1;
            e  = (t-1) / (N+1);
            kk = (t-1) % (N+1);
            if (t % (N+1) == 0) begin
               e_wr = 1; e_ca = e; e_cd = exp_c(e);
            end else begin
               e_rd = 1;
               e_aa = (e/N)*N + kk;
               e_ba = kk*N + e%N;
            end
         end
         chk("busy", busy, e_busy);
         chk("done", done, e_done);
         chk("a_read", a_read, e_rd);
         chk("b_read", b_read, e_rd);
         chk("a_addr", a_addr, e_aa);
         chk("b_addr", b_addr, e_ba);
         chk("c_write", c_write, e_wr);
         chk("c_addr", c_addr, e_ca);
         chk("c_data", c_data, e_cd);
      end
   end

   // Pulse start, then watch ncyc cycles; s1..s3 are extra start pulses and
   // rst_at the cycle with reset asserted (0 = none).
   task automatic run(input int ncyc, input int s1, input int s2, input int s3,
                      input int rst_at);
      first_wr = 0; done_cyc = 0; done_n = 0; nwr = 0;
      @(negedge clk);
      start = 1'b1;
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk);
         if (c_write) begin
            if (first_wr == 0) first_wr = c;
            if (nwr < 16) begin
               wr_addr[nwr] = int'(c_addr);
               wr_cyc[nwr]  = c;
            end
            nwr++;
         end
         if (done) begin
            done_n++;
            done_cyc = c;
         end
         start = (c == s1 || c == s2 || c == s3);
         rst   = (c != rst_at);
      end
      start = 1'b0;
      rst   = 1'b1;
   endtask

   task automatic chk_timing(input string nm);
      chk({nm, "_first_wr"}, first_wr, 3);
      chk({nm, "_done_cyc"}, done_cyc, 13);
      chk({nm, "_done_n"}, done_n, 1);
      chk({nm, "_nwr"}, nwr, 4);
      for (int q = 0; q < 4; q++) begin
         chk({nm, "_wr_addr"}, wr_addr[q], q);
         chk({nm, "_wr_cyc"}, wr_cyc[q], 3*(q+1));
      end
   endtask

   task automatic chk_c(input string nm, input int c0, input int c1,
                        input int c2, input int c3);
      chk({nm, "_c0"}, cmem[0], c0);
      chk({nm, "_c1"}, cmem[1], c1);
      chk({nm, "_c2"}, cmem[2], c2);
      chk({nm, "_c3"}, cmem[3], c3);
   endtask

   task automatic load_basic();
      mem_a[0] = 8'd1; mem_a[1] = 8'd2; mem_a[2] = 8'd3; mem_a[3] = 8'd4;
      mem_b[0] = 8'd5; mem_b[1] = 8'd6; mem_b[2] = 8'd7; mem_b[3] = 8'd8;
   endtask

   initial begin
      for (int q = 0; q < 64; q++) begin
         mem_a[q] = '0;
         mem_b[q] = '0;
      end
      load_basic();
      rst   = 1'b0;
      start = 1'b1;

      // Reset held with start high: nothing may move.
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_c_write", c_write, 0);
      rst   = 1'b1;
      start = 1'b0;
      @(negedge clk);
      chk("post_rst_busy", busy, 0);

      // Basic multiply.
      run(13, 0, 0, 0, 0);
      chk_timing("basic");
      chk_c("basic", 19, 22, 43, 50);

      // Overflow: every true element is 80000.
      for (int q = 0; q < 4; q++) begin
         mem_a[q] = 8'd200;
         mem_b[q] = 8'd200;
      end
      run(13, 0, 0, 0, 0);
      chk_timing("ovf");
      chk_c("ovf", OVF, OVF, OVF, OVF);

      // Reset in cycle 5 aborts after the first write.
      load_basic();
      run(12, 0, 0, 0, 5);
      chk("abort_nwr", nwr, 1);
      chk("abort_done_n", done_n, 0);
      chk("abort_busy", busy, 0);
      chk_c("abort", 19, OVF, OVF, OVF);

      // Restart after abort, with ignored starts while busy and in DONE.
      run(15, 4, 12, 13, 0);
      chk_timing("busy_start");
      chk_c("busy_start", 19, 22, 43, 50);

      // Back-to-back: B = identity, start one cycle after done.
      run(13, 0, 0, 0, 0);
      mem_b[0] = 8'd1; mem_b[1] = 8'd0; mem_b[2] = 8'd0; mem_b[3] = 8'd1;
      run(13, 0, 0, 0, 0);
      chk_timing("ident");
      chk_c("ident", 1, 2, 3, 4);

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
